// File: rtl/cim_pkg.sv
// Shared types and constants for the CIM/CAM array command sequencer.
package cim_pkg;

  localparam int ROWS    = 4;
  localparam int ROW_W   = 2;
  localparam int DATA_W  = 4;
  localparam int PHASE_W = 4;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'b00,
    OP_MAC    = 2'b01,
    OP_SEARCH = 2'b10,
    OP_NOP    = 2'b11
  } cim_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PRE   = 2'b01,
    ST_EVAL  = 2'b10,
    ST_RECOV = 2'b11
  } cim_state_e;

  // Next row in the sweep; the array has ROWS=4 rows so 3 wraps to 0.
  function automatic logic [ROW_W-1:0] next_row(input logic [ROW_W-1:0] row);
    return row + 1'b1;
  endfunction

endpackage

// File: rtl/cim_phase_timer.sv
// Loadable down-counter that times both the precharge and evaluate phases.
// zero is high when the phase is in its final cycle.
module cim_phase_timer
  import cim_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [PHASE_W-1:0] load_val,
  output logic               zero
);

  logic [PHASE_W-1:0] count;

  // Load on phase entry, otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/cim_array_ctrl.sv
// Command sequencer for the 4-row compute-in-memory/CAM array.
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only in IDLE (and not while
// rst_n is low), and the requester must hold the command until it transfers.
module cim_array_ctrl
  import cim_pkg::*;
#(
  parameter int PRECH_CYCLES = 1,
  parameter int EVAL_CYCLES  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ROW_W-1:0]  cmd_addr,
  input  logic [1:0]        cmd_len,
  input  logic              cmd_rbar,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              abort,
  output logic              dec_cs,
  output logic              dec_w_en,
  output logic              dec_mac_en,
  output logic              dec_read_bar,
  output logic              dec_preb_en,
  output logic [ROW_W-1:0]  dec_addr,
  output logic [DATA_W-1:0] dec_data,
  output logic              eval_valid,
  output logic [ROW_W-1:0]  eval_row,
  output logic              busy,
  output logic              done,
  output logic              done_abort,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_PRE   = ST_PRE;
  localparam logic [1:0] S_EVAL  = ST_EVAL;
  localparam logic [1:0] S_RECOV = ST_RECOV;

  localparam logic [PHASE_W-1:0] PRE_LOAD  = PHASE_W'(PRECH_CYCLES - 1);
  localparam logic [PHASE_W-1:0] EVAL_LOAD = PHASE_W'(EVAL_CYCLES - 1);

  if (PRECH_CYCLES < 1 || PRECH_CYCLES > 15) begin : g_bad_prech
    $error("PRECH_CYCLES must be in 1..15");
  end
  if (EVAL_CYCLES < 1 || EVAL_CYCLES > 15) begin : g_bad_eval
    $error("EVAL_CYCLES must be in 1..15");
  end

  logic [1:0]        state, state_nxt;
  cim_op_e           op_q, op_nxt;
  logic [ROW_W-1:0]  row_q, row_nxt;
  logic [1:0]        rem_q, rem_nxt;
  logic              rbar_q, rbar_nxt;
  logic [DATA_W-1:0] data_q, data_nxt;
  logic              abort_q, abort_nxt;
  logic              tmr_load;
  logic [PHASE_W-1:0] tmr_val;
  logic              tmr_zero;
  logic              eval_last;
  logic              active_nxt;

  cim_phase_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Next-state, command latching and row sweep decisions.
  always_comb begin
    state_nxt = state;
    op_nxt    = op_q;
    row_nxt   = row_q;
    rem_nxt   = rem_q;
    rbar_nxt  = rbar_q;
    data_nxt  = data_q;
    abort_nxt = abort_q;
    tmr_load  = 1'b0;
    tmr_val   = PRE_LOAD;
    eval_last = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          op_nxt    = cim_op_e'(cmd_op);
          row_nxt   = cmd_addr;
          rem_nxt   = (cmd_op == OP_MAC) ? cmd_len : 2'd0;
          rbar_nxt  = cmd_rbar;
          data_nxt  = cmd_data;
          abort_nxt = 1'b0;
          tmr_load  = 1'b1;
          tmr_val   = PRE_LOAD;
          state_nxt = (cmd_op == OP_NOP) ? S_RECOV : S_PRE;
        end
      end
      S_PRE: begin
        if (abort) begin
          abort_nxt = 1'b1;
          state_nxt = S_RECOV;
        end else if (tmr_zero) begin
          tmr_load  = 1'b1;
          tmr_val   = EVAL_LOAD;
          state_nxt = S_EVAL;
        end
      end
      S_EVAL: begin
        if (abort) begin
          abort_nxt = 1'b1;
          state_nxt = S_RECOV;
        end else if (tmr_zero) begin
          eval_last = 1'b1;
          if (op_q == OP_MAC && rem_q != 2'd0) begin
            row_nxt   = next_row(row_q);
            rem_nxt   = rem_q - 1'b1;
            tmr_load  = 1'b1;
            tmr_val   = PRE_LOAD;
            state_nxt = S_PRE;
          end else begin
            state_nxt = S_RECOV;
          end
        end
      end
      S_RECOV: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign active_nxt = (state_nxt == S_PRE) || (state_nxt == S_EVAL);

  // State, latched command, and registered decoder controls derived from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      op_q         <= OP_NOP;
      row_q        <= '0;
      rem_q        <= '0;
      rbar_q       <= 1'b0;
      data_q       <= '0;
      abort_q      <= 1'b0;
      dec_cs       <= 1'b0;
      dec_w_en     <= 1'b0;
      dec_mac_en   <= 1'b0;
      dec_read_bar <= 1'b0;
      dec_preb_en  <= 1'b0;
      dec_addr     <= '0;
      dec_data     <= '0;
    end else begin
      state        <= state_nxt;
      op_q         <= op_nxt;
      row_q        <= row_nxt;
      rem_q        <= rem_nxt;
      rbar_q       <= rbar_nxt;
      data_q       <= data_nxt;
      abort_q      <= abort_nxt;
      dec_cs       <= active_nxt;
      dec_w_en     <= active_nxt && (op_nxt == OP_WRITE);
      dec_mac_en   <= active_nxt && (op_nxt == OP_MAC);
      dec_read_bar <= active_nxt && (op_nxt == OP_MAC) && rbar_nxt;
      dec_preb_en  <= (state_nxt == S_EVAL);
      dec_addr     <= active_nxt ? row_nxt : '0;
      dec_data     <= (active_nxt && (op_nxt == OP_WRITE || op_nxt == OP_SEARCH))
                      ? data_nxt : '0;
    end
  end

  assign eval_valid = eval_last;
  assign eval_row   = eval_last ? row_q : '0;
  assign cmd_ready  = rst_n && (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_RECOV);
  assign done_abort = done && abort_q;
  assign dbg_state  = state;

endmodule
